// File: rtl/key_event.sv
`default_nettype none
// ============================================================================
// key_event : turns a debounced key level into one-cycle press, release,
//             click, double-click, long-press and auto-repeat pulses.
// Revision  : 1.0
// ============================================================================
module key_event #(
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned GAP_CYCLES    = 12_500_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic click_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic busy
);

  localparam int unsigned c_MAX_LG     = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
  localparam int unsigned c_MAX_CYCLES = (c_MAX_LG > REPEAT_CYCLES) ? c_MAX_LG : REPEAT_CYCLES;
  localparam int unsigned c_CNT_W      = $clog2(c_MAX_CYCLES);

  localparam logic [c_CNT_W-1:0] c_LONG_TC   = c_CNT_W'(LONG_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_TC    = c_CNT_W'(GAP_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_REPEAT_TC = c_CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HELD1 = 3'd1,
    ST_GAP   = 3'd2,
    ST_HELD2 = 3'd3,
    ST_LONG  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic               key_d_q;
  logic               busy_q;
  logic               press_q, press_d;
  logic               release_q, release_d;
  logic               click_q, click_d;
  logic               double_q, double_d;
  logic               long_q, long_d;
  logic               repeat_q, repeat_d;

  logic               w_rise;
  logic               w_fall;
  logic               w_rep_wrap;

  assign w_rise = key_level & ~key_d_q;
  assign w_fall = ~key_level & key_d_q;

  always_comb begin
    state_d    = state_q;
    press_d    = w_rise;
    release_d  = w_fall;
    click_d    = 1'b0;
    double_d   = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;
    w_rep_wrap = 1'b0;

    // Edge tests take priority over terminal counts in every state.
    case (state_q)
      ST_IDLE: begin
        if (w_rise) begin
          state_d = ST_HELD1;
        end
      end
      ST_HELD1: begin
        if (w_fall) begin
          state_d = ST_GAP;
        end else if (cnt_q == c_LONG_TC) begin
          long_d  = 1'b1;
          state_d = ST_LONG;
        end
      end
      ST_GAP: begin
        if (w_rise) begin
          state_d = ST_HELD2;
        end else if (cnt_q == c_GAP_TC) begin
          click_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_HELD2: begin
        if (w_fall) begin
          double_d = 1'b1;
          state_d  = ST_IDLE;
        end else if (cnt_q == c_LONG_TC) begin
          // The first press was a complete click; the second became a hold.
          click_d = 1'b1;
          long_d  = 1'b1;
          state_d = ST_LONG;
        end
      end
      ST_LONG: begin
        if (w_fall) begin
          state_d = ST_IDLE;
        end else if (cnt_q == c_REPEAT_TC) begin
          repeat_d   = 1'b1;
          w_rep_wrap = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if ((state_d != state_q) || w_rep_wrap || (state_q == ST_IDLE)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + c_CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      key_d_q   <= 1'b0;
      busy_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_d_q   <= key_level;
      busy_q    <= (state_d != ST_IDLE);
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      double_q  <= double_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign click_pulse   = click_q;
  assign double_pulse  = double_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_key_event.sv
`default_nettype none
// ============================================================================
// tb_key_event : directed scoreboard bench for key_event (LONG=20, GAP=10, REPEAT=5).
// Revision     : 1.0
// ============================================================================
module tb_key_event;

  localparam int unsigned LONG_CYCLES   = 20;
  localparam int unsigned GAP_CYCLES    = 10;
  localparam int unsigned REPEAT_CYCLES = 5;

  // Pulse vector order: {press, release, click, double, long, repeat}
  localparam logic [5:0] c_P  = 6'b100000;
  localparam logic [5:0] c_R  = 6'b010000;
  localparam logic [5:0] c_C  = 6'b001000;
  localparam logic [5:0] c_D  = 6'b000100;
  localparam logic [5:0] c_L  = 6'b000010;
  localparam logic [5:0] c_RP = 6'b000001;

  logic clk = 1'b0;
  logic rst;
  logic key_level;
  logic press_pulse, release_pulse, click_pulse, double_pulse;
  logic long_pulse, repeat_pulse, busy;

  typedef struct {
    int         cyc;
    logic [5:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  key_event #(
    .LONG_CYCLES  (LONG_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .key_level    (key_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .click_pulse  (click_pulse),
    .double_pulse (double_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(input int c, input logic [5:0] v);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    exp_q.push_back(e);
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  // Holds key_level for n clocks; returns #1 after the n-th rising edge.
  task automatic drive(input logic lvl, input int n);
    key_level = lvl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic settle(input string name);
    drive(1'b0, 6);
    check({name, "_idle_busy"}, int'(busy), 0);
    check({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  // Monitor: each cycle, compare the DUT pulse vector with the scoreboard head.
  initial begin : monitor
    exp_t       e;
    logic [5:0] act;
    forever begin
      @(negedge clk);
      act = {press_pulse, release_pulse, click_pulse, double_pulse, long_pulse, repeat_pulse};
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missing_pulse cyc=%0d got=none required=%b", e.cyc, e.v);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        n_checks++;
        if (act !== e.v) begin
          n_fail++;
          $display("FAIL pulse_vector cyc=%0d got=%b required=%b", cyc, act, e.v);
        end
      end else if (act !== 6'b000000) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse cyc=%0d got=%b required=000000", cyc, act);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int t0;
    int n;

    rst       = 1'b1;
    key_level = 1'b0;

    // Reset held while the key toggles: everything stays quiet.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      key_level = ~key_level;
      check("reset_outputs",
            int'({press_pulse, release_pulse, click_pulse, double_pulse,
                  long_pulse, repeat_pulse, busy}), 0);
    end

    // Key held through reset release is seen as a press; reset mid-sequence aborts.
    key_level = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    t0  = cyc;
    n   = t0 + 1;
    push(n, c_P);
    drive(1'b1, 1);
    check("reset_release_busy", int'(busy), 1);
    drive(1'b1, 3);
    rst = 1'b1;
    #1;
    check("reset_abort_busy", int'(busy), 0);
    key_level = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    drive(1'b0, 25);
    settle("reset");

    // Single click.
    t0 = cyc;
    n  = t0 + 1;
    push(n,      c_P);
    push(n + 5,  c_R);
    push(n + 15, c_C);
    drive(1'b1, 5);
    drive(1'b0, 12);
    check("click_busy_after", int'(busy), 0);
    settle("click");

    // Double click.
    t0 = cyc;
    n  = t0 + 1;
    push(n,      c_P);
    push(n + 3,  c_R);
    push(n + 7,  c_P);
    push(n + 10, c_R | c_D);
    drive(1'b1, 3);
    drive(1'b0, 4);
    drive(1'b1, 3);
    drive(1'b0, 15);
    settle("double");

    // Long hold with auto-repeat.
    t0 = cyc;
    n  = t0 + 1;
    push(n,      c_P);
    push(n + 20, c_L);
    push(n + 25, c_RP);
    push(n + 30, c_RP);
    push(n + 32, c_R);
    drive(1'b1, 10);
    check("long_busy_held", int'(busy), 1);
    drive(1'b1, 22);
    drive(1'b0, 15);
    settle("long");

    // Second rise on the GAP terminal cycle: rise wins, no click.
    t0 = cyc;
    n  = t0 + 1;
    push(n,      c_P);
    push(n + 5,  c_R);
    push(n + 15, c_P);
    push(n + 18, c_R | c_D);
    drive(1'b1, 5);
    drive(1'b0, 10);
    drive(1'b1, 3);
    drive(1'b0, 15);
    settle("gap_edge");

    // Fall on the HELD1 terminal cycle: fall wins, click later, no long.
    t0 = cyc;
    n  = t0 + 1;
    push(n,      c_P);
    push(n + 20, c_R);
    push(n + 30, c_C);
    drive(1'b1, 20);
    drive(1'b0, 15);
    settle("held1_edge");

    // Second press held: click and long together, then repeats.
    t0 = cyc;
    n  = t0 + 1;
    push(n,      c_P);
    push(n + 3,  c_R);
    push(n + 7,  c_P);
    push(n + 27, c_C | c_L);
    push(n + 32, c_RP);
    push(n + 37, c_RP);
    push(n + 40, c_R);
    drive(1'b1, 3);
    drive(1'b0, 4);
    drive(1'b1, 33);
    drive(1'b0, 15);
    settle("held2_long");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_event.md
Name: key_event

Overview:
- Consumes the debounced, stable key level produced by the debounce stage and classifies it into single-cycle event pulses: press, release, single click, double click, long press and auto-repeat while held.
- Sits directly downstream of the debouncer and upstream of the lab's control and display logic.
- Fully synchronous, one clock domain, no handshake; every output is registered.

Parameters:
- LONG_CYCLES, 50_000_000, hold time in clocks before long_pulse fires (1 s at 50 MHz); must be >= 2.
- GAP_CYCLES, 12_500_000, maximum release-to-second-press gap for a double click; must be >= 2.
- REPEAT_CYCLES, 10_000_000, auto-repeat period after long_pulse; must be >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- key_level  input  1  debounced key level from the debounce stage; 1 = pressed. Already synchronous to clk.
- press_pulse  output  1  one-cycle pulse on a 0->1 edge of key_level.
- release_pulse  output  1  one-cycle pulse on a 1->0 edge of key_level.
- click_pulse  output  1  one-cycle pulse when a single click is confirmed.
- double_pulse  output  1  one-cycle pulse when a double click is confirmed.
- long_pulse  output  1  one-cycle pulse when the hold time reaches LONG_CYCLES.
- repeat_pulse  output  1  one-cycle pulse every REPEAT_CYCLES while held after a long press.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: key_d, cnt, all pulse outputs and busy are 0; state is IDLE. Reset is asynchronous assert and synchronous-edge release. A reset asserted mid-sequence aborts it with no pulses.
- key_d holds key_level delayed by one clock.
  - rise = key_level & ~key_d; fall = ~key_level & key_d.
  - A key held through reset release is therefore seen as a press on the first clock after reset.
- Latency: press_pulse and release_pulse go high for the one cycle following the clock edge that samples the edge, i.e. 1 clock after key_level changes.
- cnt is an unsigned counter of width $clog2(max(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES)). It is cleared on every state transition and increments each cycle the FSM stays in the same state.
- All pulse outputs default to 0 every cycle and are set only for a single cycle.
- FSM states and transitions:
  - IDLE: on rise, go to HELD1.
  - HELD1 (first press):
    - fall -> release_pulse, go to GAP.
    - else if cnt == LONG_CYCLES-1 -> long_pulse, go to LONG.
    - If fall and the terminal count occur in the same cycle, fall wins (short click).
  - GAP (waiting for a second press):
    - rise -> press_pulse, go to HELD2.
    - else if cnt == GAP_CYCLES-1 -> click_pulse, go to IDLE.
    - If rise and timeout occur in the same cycle, rise wins (no click_pulse).
  - HELD2 (second press):
    - fall -> release_pulse and double_pulse in the same cycle, go to IDLE.
    - else if cnt == LONG_CYCLES-1 -> click_pulse (for the first press) and long_pulse in the same cycle, go to LONG.
  - LONG:
    - fall -> release_pulse, go to IDLE; no click.
    - else if cnt == REPEAT_CYCLES-1 -> repeat_pulse, cnt reset to 0, stay in LONG.
- press_pulse and release_pulse are generated from rise/fall in every state, independent of the classification.
- The counter never wraps: every state exits or clears at its terminal count.
- busy = (state != IDLE), registered alongside the state.

Test Plan:
Benches use LONG_CYCLES=20, GAP_CYCLES=10, REPEAT_CYCLES=5; cycle N is the cycle press_pulse is high.
- Reset: rst=1 with key_level toggling -> all outputs 0. Release rst with key_level=1 -> press_pulse 1 clock later. Reassert rst at N+3 -> busy=0 immediately and no later pulses.
- Single click: key high 5 cycles, then low -> press_pulse at N, release_pulse at N+5, click_pulse exactly 10 clocks after release_pulse, busy low 1 clock after click_pulse, no double/long pulses.
- Double click: high 3, low 4, high 3, low -> two press_pulse, double_pulse coincident with the second release_pulse, no click_pulse.
- Long hold: key high 32 cycles -> long_pulse at N+20, repeat_pulse at N+25 and N+30, release_pulse at N+32, no click_pulse.
- Boundary:
  - Second rise landing exactly on the GAP timeout cycle -> HELD2 entered, no click_pulse.
  - Fall landing on the HELD1 terminal cycle -> release_pulse only, then click_pulse 10 clocks later, no long_pulse.
- Second press held 20 cycles -> click_pulse and long_pulse in the same cycle, followed by repeat_pulse every 5 clocks.
